// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared types and constants for the shape-guessing game controller.
//   shape_t      - one shape code, 0 means an empty slot
//   score_t      - exact / partial match count (0..4)
//   seq_state_t  - round controller states
//   scr_phase_t  - scorer walk phase
// -----------------------------------------------------------------------------
package game_pkg;

    localparam int SHAPE_W_DEF = 3;
    localparam int NUM_SLOTS   = 4;

    typedef logic [SHAPE_W_DEF-1:0] shape_t;
    localparam shape_t SHAPE_EMPTY = '0;

    typedef logic [2:0] score_t;

    typedef enum logic [2:0] {
        LOAD, PLAY, EXACT, PART, REPORT, WON, LOST
    } seq_state_t;

    typedef enum logic [1:0] {
        SC_IDLE, SC_EXACT, SC_PART
    } scr_phase_t;

endpackage

// File: rtl/guess_scorer.sv
// -----------------------------------------------------------------------------
// guess_scorer
// Multi-cycle scorer: captures a guess on start_i, spends four cycles on the
// exact pass and four on the partial pass, then pulses done_o with the counts.
//   clk_i, rst_ni    clock, async active-low reset
//   start_i          capture guess_i and begin scoring
//   guess_i          four guess shapes (slot 0 in the low element)
//   master_i         four stored master shapes
//   done_o           one-cycle pulse, counts valid
//   exact_o, part_o  exact and right-shape/wrong-slot counts
// -----------------------------------------------------------------------------
module guess_scorer
    import game_pkg::*;
#(
    parameter int SHAPE_W = SHAPE_W_DEF
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              start_i,
    input  logic [NUM_SLOTS-1:0][SHAPE_W-1:0] guess_i,
    input  logic [NUM_SLOTS-1:0][SHAPE_W-1:0] master_i,
    output logic                              done_o,
    output score_t                            exact_o,
    output score_t                            part_o
);

    scr_phase_t                        phase_q;
    logic [1:0]                        idx_q;
    logic [NUM_SLOTS-1:0][SHAPE_W-1:0] g_q;
    logic [NUM_SLOTS-1:0]              gUsed_q;
    logic [NUM_SLOTS-1:0]              mUsed_q;
    score_t                            exact_q;
    score_t                            part_q;
    logic                              done_q;

    // Lowest unused master slot holding the current guess shape. The loop runs
    // high-to-low so the last (lowest) match wins.
    logic       hit;
    logic [1:0] hit_j;
    always_comb begin
        hit   = 1'b0;
        hit_j = '0;
        for (int j = NUM_SLOTS-1; j >= 0; j--) begin
            if (!mUsed_q[j] && (master_i[j] == g_q[idx_q])) begin
                hit   = 1'b1;
                hit_j = 2'(j);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= SC_IDLE;
            idx_q   <= '0;
            g_q     <= '0;
            gUsed_q <= '0;
            mUsed_q <= '0;
            exact_q <= '0;
            part_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (phase_q)
                SC_IDLE: if (start_i) begin
                    g_q     <= guess_i;
                    gUsed_q <= '0;
                    mUsed_q <= '0;
                    exact_q <= '0;
                    part_q  <= '0;
                    idx_q   <= '0;
                    phase_q <= SC_EXACT;
                end
                SC_EXACT: begin
                    if (g_q[idx_q] == master_i[idx_q]) begin
                        gUsed_q[idx_q] <= 1'b1;
                        mUsed_q[idx_q] <= 1'b1;
                        exact_q        <= exact_q + 3'd1;
                    end
                    idx_q <= idx_q + 2'd1;
                    if (idx_q == 2'd3) phase_q <= SC_PART;
                end
                SC_PART: begin
                    // mUsed updates each cycle, so a master slot is claimed once.
                    if (!gUsed_q[idx_q] && hit) begin
                        mUsed_q[hit_j] <= 1'b1;
                        part_q         <= part_q + 3'd1;
                    end
                    idx_q <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        phase_q <= SC_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: phase_q <= SC_IDLE;
            endcase
        end
    end

    assign done_o  = done_q;
    assign exact_o = exact_q;
    assign part_o  = part_q;

endmodule

// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
// Round controller: master-load gating, guess handshake, scoring, round count
// and win/loss. Optional macro GUESS_CHECK_EN adds the guessError output and
// rejects guesses containing an empty (0) slot.
//   CLOCK_50, reset            clock, async active-low reset
//   startGame, masterLoaded    game start / restart control
//   master0..3, guess0..3      shapes; guessValid/guessReady handshake
//   gamePlaying, scoreValid    status; znarly/zood scores, roundNum
//   gameWon, gameLost          held end-of-game flags
//   masterClear                pulse emptying master registers
//   guessError (macro only)    pulse on a rejected guess
// All outputs are registered.
// -----------------------------------------------------------------------------
module game_sequencer
    import game_pkg::*;
#(
    parameter int MAX_ROUNDS = 8,
    parameter int SHAPE_W    = SHAPE_W_DEF
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               startGame,
    input  logic               masterLoaded,
    input  logic [SHAPE_W-1:0] master0,
    input  logic [SHAPE_W-1:0] master1,
    input  logic [SHAPE_W-1:0] master2,
    input  logic [SHAPE_W-1:0] master3,
    input  logic [SHAPE_W-1:0] guess0,
    input  logic [SHAPE_W-1:0] guess1,
    input  logic [SHAPE_W-1:0] guess2,
    input  logic [SHAPE_W-1:0] guess3,
    input  logic               guessValid,
    output logic               guessReady,
    output logic               gamePlaying,
    output logic               scoreValid,
    output logic [2:0]         znarly,
    output logic [2:0]         zood,
    output logic [3:0]         roundNum,
    output logic               gameWon,
    output logic               gameLost,
    output logic               masterClear
`ifdef GUESS_CHECK_EN
    ,
    output logic               guessError
`endif
);

    seq_state_t state_q;
    logic [1:0] step_q;
    logic       guessReady_q, gamePlaying_q, scoreValid_q;
    score_t     znarly_q, zood_q;
    logic [3:0] roundNum_q;
    logic       gameWon_q, gameLost_q, masterClear_q;

    logic       sc_done;
    score_t     sc_exact, sc_part;

    // guessReady_q is high exactly while in PLAY
    logic handshake, guess_ok, start;
    assign handshake = guessValid & guessReady_q;
`ifdef GUESS_CHECK_EN
    logic guessError_q;
    assign guess_ok = (guess0 != '0) && (guess1 != '0) && (guess2 != '0) && (guess3 != '0);
`else
    assign guess_ok = 1'b1;
`endif
    assign start = handshake & guess_ok;

    guess_scorer #(.SHAPE_W(SHAPE_W)) u_scorer (
        .clk_i    (CLOCK_50),
        .rst_ni   (reset),
        .start_i  (start),
        .guess_i  ({guess3, guess2, guess1, guess0}),
        .master_i ({master3, master2, master1, master0}),
        .done_o   (sc_done),
        .exact_o  (sc_exact),
        .part_o   (sc_part)
    );

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q       <= LOAD;
            step_q        <= '0;
            guessReady_q  <= 1'b0;
            gamePlaying_q <= 1'b0;
            scoreValid_q  <= 1'b0;
            znarly_q      <= '0;
            zood_q        <= '0;
            roundNum_q    <= '0;
            gameWon_q     <= 1'b0;
            gameLost_q    <= 1'b0;
            masterClear_q <= 1'b0;
`ifdef GUESS_CHECK_EN
            guessError_q  <= 1'b0;
`endif
        end else begin
            scoreValid_q  <= 1'b0;
            masterClear_q <= 1'b0;
`ifdef GUESS_CHECK_EN
            guessError_q  <= 1'b0;
`endif
            case (state_q)
                LOAD: if (startGame && masterLoaded) begin
                    state_q       <= PLAY;
                    roundNum_q    <= '0;
                    guessReady_q  <= 1'b1;
                    gamePlaying_q <= 1'b1;
                end
                PLAY: if (handshake) begin
                    if (guess_ok) begin
                        state_q      <= EXACT;
                        step_q       <= '0;
                        guessReady_q <= 1'b0;
                    end
`ifdef GUESS_CHECK_EN
                    else guessError_q <= 1'b1;
`endif
                end
                // Tracks the scorer's exact pass; the scorer owns the work.
                EXACT: begin
                    step_q <= step_q + 2'd1;
                    if (step_q == 2'd3) state_q <= PART;
                end
                PART: if (sc_done) begin
                    state_q      <= REPORT;
                    znarly_q     <= sc_exact;
                    zood_q       <= sc_part;
                    scoreValid_q <= 1'b1;
                    roundNum_q   <= roundNum_q + 4'd1;
                end
                REPORT: begin
                    if (znarly_q == 3'd4) begin
                        state_q       <= WON;
                        gameWon_q     <= 1'b1;
                        gamePlaying_q <= 1'b0;
                    end else if (roundNum_q == 4'(MAX_ROUNDS)) begin
                        state_q       <= LOST;
                        gameLost_q    <= 1'b1;
                        gamePlaying_q <= 1'b0;
                    end else begin
                        state_q      <= PLAY;
                        guessReady_q <= 1'b1;
                    end
                end
                WON, LOST: if (startGame) begin
                    state_q       <= LOAD;
                    masterClear_q <= 1'b1;
                    znarly_q      <= '0;
                    zood_q        <= '0;
                    roundNum_q    <= '0;
                    gameWon_q     <= 1'b0;
                    gameLost_q    <= 1'b0;
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign guessReady  = guessReady_q;
    assign gamePlaying = gamePlaying_q;
    assign scoreValid  = scoreValid_q;
    assign znarly      = znarly_q;
    assign zood        = zood_q;
    assign roundNum    = roundNum_q;
    assign gameWon     = gameWon_q;
    assign gameLost    = gameLost_q;
    assign masterClear = masterClear_q;
`ifdef GUESS_CHECK_EN
    assign guessError  = guessError_q;
`endif

endmodule

// File: tb/tb_game_sequencer.sv
module tb_game_sequencer;

    localparam int MAXR = 8;

    logic       CLOCK_50 = 1'b0;
    logic       reset, startGame, masterLoaded, guessValid;
    logic [2:0] master0, master1, master2, master3;
    logic [2:0] guess0, guess1, guess2, guess3;
    logic       guessReady, gamePlaying, scoreValid, gameWon, gameLost, masterClear;
    logic [2:0] znarly, zood;
    logic [3:0] roundNum;
`ifdef GUESS_CHECK_EN
    logic       guessError;
`endif

    int total = 0;
    int bad   = 0;
    int m[4];
    int g[4];
    int rounds;
    bit over;

    always #5 CLOCK_50 = ~CLOCK_50;

    game_sequencer #(.MAX_ROUNDS(MAXR), .SHAPE_W(3)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .startGame(startGame), .masterLoaded(masterLoaded),
        .master0(master0), .master1(master1), .master2(master2), .master3(master3),
        .guess0(guess0), .guess1(guess1), .guess2(guess2), .guess3(guess3),
        .guessValid(guessValid), .guessReady(guessReady), .gamePlaying(gamePlaying),
        .scoreValid(scoreValid), .znarly(znarly), .zood(zood), .roundNum(roundNum),
        .gameWon(gameWon), .gameLost(gameLost), .masterClear(masterClear)
`ifdef GUESS_CHECK_EN
        , .guessError(guessError)
`endif
    );

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: exact hits, then per-shape min of leftover counts
    // (a greedy slot-by-slot claim always reaches this maximum).
    function automatic void score(output int ex, output int pa);
        int cg[8];
        int cm[8];
        for (int s = 0; s < 8; s++) begin cg[s] = 0; cm[s] = 0; end
        ex = 0;
        pa = 0;
        for (int i = 0; i < 4; i++) begin
            if (g[i] == m[i]) ex++;
            else begin cg[g[i]]++; cm[m[i]]++; end
        end
        for (int s = 0; s < 8; s++) pa += (cg[s] < cm[s]) ? cg[s] : cm[s];
    endfunction

    task automatic drive_master();
        master0 = 3'(m[0]); master1 = 3'(m[1]); master2 = 3'(m[2]); master3 = 3'(m[3]);
    endtask

    task automatic start_game();
        drive_master();
        masterLoaded = 1'b1;
        startGame    = 1'b1;
        step();
        startGame = 1'b0;
        rounds    = 0;
        over      = 1'b0;
        chk("start_playing", gamePlaying, 1);
        chk("start_ready", guessReady, 1);
        chk("start_round", roundNum, 0);
    endtask

    task automatic end_game();
        startGame = 1'b1;
        step();
        startGame    = 1'b0;
        masterLoaded = 1'b0;
        chk("clr_pulse", masterClear, 1);
        chk("clr_znarly", znarly, 0);
        chk("clr_zood", zood, 0);
        chk("clr_round", roundNum, 0);
        chk("clr_won", gameWon, 0);
        chk("clr_lost", gameLost, 0);
        step();
        chk("clr_pulse_end", masterClear, 0);
        chk("load_playing", gamePlaying, 0);
        chk("load_ready", guessReady, 0);
    endtask

    task automatic do_guess();
        int ex, pa, n;
        bit zero;
        score(ex, pa);
        zero = (g[0] == 0) || (g[1] == 0) || (g[2] == 0) || (g[3] == 0);
        drive_master();
        guess0 = 3'(g[0]); guess1 = 3'(g[1]); guess2 = 3'(g[2]); guess3 = 3'(g[3]);
        guessValid = 1'b1;
        chk("ready_before", guessReady, 1);
        step();
        guessValid = 1'b0;
        // Scrambled inputs must not affect the captured guess
        guess0 = 3'($urandom); guess1 = 3'($urandom); guess2 = 3'($urandom); guess3 = 3'($urandom);
`ifdef GUESS_CHECK_EN
        if (zero) begin
            chk("gerr_pulse", guessError, 1);
            chk("gerr_ready", guessReady, 1);
            n = 0;
            repeat (12) begin step(); if (scoreValid) n++; end
            chk("gerr_noscore", n, 0);
            chk("gerr_round", roundNum, rounds);
            chk("gerr_ready_hold", guessReady, 1);
            return;
        end
`else
        if (zero) chk("zero_ready_low", guessReady, 0);
`endif
        n = 0;
        while (scoreValid !== 1'b1 && n < 20) begin step(); n++; end
        chk("score_latency", n, 9);
        rounds++;
        chk("znarly", znarly, ex);
        chk("zood", zood, pa);
        chk("round", roundNum, rounds);
        step();
        chk("score_pulse", scoreValid, 0);
        if (ex == 4) begin
            over = 1'b1;
            chk("won", gameWon, 1);
            chk("won_playing", gamePlaying, 0);
        end else if (rounds == MAXR) begin
            over = 1'b1;
            chk("lost", gameLost, 1);
            chk("lost_playing", gamePlaying, 0);
        end else begin
            chk("next_ready", guessReady, 1);
            chk("next_playing", gamePlaying, 1);
        end
    endtask

    initial begin
        int n;
        reset = 1'b0; startGame = 1'b0; masterLoaded = 1'b0; guessValid = 1'b0;
        master0 = '0; master1 = '0; master2 = '0; master3 = '0;
        guess0 = '0; guess1 = '0; guess2 = '0; guess3 = '0;
        repeat (3) step();
        chk("rst_ready", guessReady, 0);
        chk("rst_playing", gamePlaying, 0);
        chk("rst_score", scoreValid, 0);
        chk("rst_znarly", znarly, 0);
        chk("rst_zood", zood, 0);
        chk("rst_round", roundNum, 0);
        chk("rst_won", gameWon, 0);
        chk("rst_lost", gameLost, 0);
        chk("rst_clear", masterClear, 0);
        reset = 1'b1;
        step();

        // guessValid in LOAD is ignored
        guessValid = 1'b1;
        repeat (2) step();
        chk("load_ignore_ready", guessReady, 0);
        chk("load_ignore_score", scoreValid, 0);
        guessValid = 1'b0;

        // Win on first guess
        m = '{1, 2, 3, 4};
        start_game();
        g = '{1, 2, 3, 4};
        do_guess();
        end_game();

        // Permutation, zero-slot guess, duplicates
        m = '{1, 2, 3, 4};
        start_game();
        g = '{4, 3, 2, 1}; do_guess();
        g = '{1, 0, 2, 3}; do_guess();
        m = '{1, 1, 2, 2}; g = '{1, 2, 1, 5}; do_guess();
        m = '{3, 3, 3, 3}; g = '{3, 1, 1, 1}; do_guess();

        // Loss: keep guessing 5555 against 1234 until the round limit
        m = '{1, 2, 3, 4};
        g = '{5, 5, 5, 5};
        n = 0;
        while (!over && n < 20) begin do_guess(); n++; end
        chk("loss_round", roundNum, MAXR);
        chk("loss_flag", gameLost, 1);
        end_game();

        // Randomized games against the reference model
        for (int gm = 0; gm < 6; gm++) begin
            for (int i = 0; i < 4; i++) m[i] = $urandom_range(1, 5);
            start_game();
            n = 0;
            while (!over && n < 20) begin
                for (int i = 0; i < 4; i++)
                    g[i] = ($urandom_range(0, 3) == 0) ? m[i] : $urandom_range(1, 5);
                do_guess();
                n++;
            end
            end_game();
        end

        // Reset while the partial pass is running
        m = '{1, 2, 3, 4};
        start_game();
        drive_master();
        guess0 = 3'd4; guess1 = 3'd3; guess2 = 3'd2; guess3 = 3'd1;
        guessValid = 1'b1;
        step();
        guessValid = 1'b0;
        repeat (6) step();
        reset = 1'b0;
        #1;
        chk("midrst_playing", gamePlaying, 0);
        chk("midrst_score", scoreValid, 0);
        chk("midrst_zood", zood, 0);
        chk("midrst_ready", guessReady, 0);
        repeat (2) step();
        reset = 1'b1;
        n = 0;
        repeat (12) begin step(); if (scoreValid) n++; end
        chk("midrst_noscore", n, 0);
        chk("midrst_load_playing", gamePlaying, 0);
        chk("midrst_load_ready", guessReady, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
